// File: rtl/alu_mul_seq_if.sv
// Request/result bus and borrowed-alu lines of the shift-and-add multiply sequencer.
// master = requester plus alu owner side; slave = the sequencer itself.
interface alu_mul_seq_if #(
  parameter int DATAWIDTH  = 16,
  parameter int ALUOPWIDTH = 4
);
  logic                  start;
  logic [DATAWIDTH-1:0]  opA;
  logic [DATAWIDTH-1:0]  opB;
  logic                  busy;
  logic                  done;
  logic [DATAWIDTH-1:0]  product;
  logic                  aluReq;
  logic                  aluGnt;
  logic [DATAWIDTH-1:0]  aluSrc;
  logic [DATAWIDTH-1:0]  aluDst;
  logic [ALUOPWIDTH-1:0] aluOp;
  logic [DATAWIDTH-1:0]  aluResult;

  modport master (
    output start, opA, opB, aluGnt, aluResult,
    input  busy, done, product, aluReq, aluSrc, aluDst, aluOp
  );

  modport slave (
    input  start, opA, opB, aluGnt, aluResult,
    output busy, done, product, aluReq, aluSrc, aluDst, aluOp
  );
endinterface

// File: rtl/alu_mul_seq.sv
// Multi-cycle unsigned multiply using ADDU/SLL micro-ops on a borrowed alu; done = 2*MBITS+1 cycles after start, each ungranted cycle stalls one more.
// Optional MULSEQ_EARLY_EXIT_EN finishes as soon as no multiplier bits remain.
module alu_mul_seq #(
  parameter int MBITS      = 8,
  parameter int DATAWIDTH  = 16,
  parameter int ALUOPWIDTH = 4,
  parameter logic [ALUOPWIDTH-1:0] ALUOp_MOV  = 4'h0,
  parameter logic [ALUOPWIDTH-1:0] ALUOp_ADDU = 4'h3,
  parameter logic [ALUOPWIDTH-1:0] ALUOp_SLL  = 4'h9
) (
  input logic          clk,
  input logic          rst_n,
  alu_mul_seq_if.slave bus
);

`ifdef MULSEQ_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  localparam int CW = $clog2(MBITS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MBITS);

  typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} state_t;

  state_t               state;
  logic [DATAWIDTH-1:0] acc;
  logic [DATAWIDTH-1:0] mcand;
  logic [MBITS-1:0]     mplier;
  logic [CW-1:0]        count;
  logic [CW-1:0]        count_nxt;
  logic                 busy_r;
  logic                 done_r;
  logic [DATAWIDTH-1:0] product_r;
  logic                 alu_req;
  logic [ALUOPWIDTH-1:0] alu_op;
  logic [DATAWIDTH-1:0] alu_src;
  logic [DATAWIDTH-1:0] alu_dst;
  logic                 unused_bits;

  assign count_nxt   = count + CW'(1);
  assign unused_bits = ^{bus.opA[DATAWIDTH-1:MBITS], bus.opB[DATAWIDTH-1:MBITS]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      count     <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      product_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            acc    <= '0;
            mcand  <= {{(DATAWIDTH-MBITS){1'b0}}, bus.opA[MBITS-1:0]};
            mplier <= bus.opB[MBITS-1:0];
            count  <= '0;
            if (EARLY && bus.opB[MBITS-1:0] == '0) begin
              product_r <= '0;
              done_r    <= 1'b1;
              state     <= DONE;
            end else begin
              busy_r <= 1'b1;
              state  <= ADD;
            end
          end
        end
        ADD: begin
          if (bus.aluGnt) begin
            if (mplier[0]) acc <= bus.aluResult;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (bus.aluGnt) begin
            mcand  <= bus.aluResult;
            mplier <= mplier >> 1;
            count  <= count_nxt;
            // acc is already final here: the last SHIFT never touches it
            if (count_nxt == CNT_LAST || (EARLY && (mplier >> 1) == '0)) begin
              product_r <= acc;
              busy_r    <= 1'b0;
              done_r    <= 1'b1;
              state     <= DONE;
            end else begin
              state <= ADD;
            end
          end
        end
        DONE: begin
          done_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    alu_req = 1'b0;
    alu_op  = ALUOp_MOV;
    alu_src = '0;
    alu_dst = '0;
    case (state)
      ADD: begin
        alu_req = 1'b1;
        alu_op  = ALUOp_ADDU;
        alu_dst = acc;
        alu_src = mcand;
      end
      SHIFT: begin
        alu_req = 1'b1;
        alu_op  = ALUOp_SLL;
        alu_dst = mcand;
        alu_src = DATAWIDTH'(1);
      end
      default: ;
    endcase
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.product = product_r;
  assign bus.aluReq  = alu_req;
  assign bus.aluOp   = alu_op;
  assign bus.aluSrc  = alu_src;
  assign bus.aluDst  = alu_dst;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Scoreboarded random/directed bench for alu_mul_seq with a behavioural alu and a grant-counting reference.
module tb_alu_mul_seq;
  localparam int MBITS = 8;
  localparam logic [3:0] OP_MOV  = 4'h0;
  localparam logic [3:0] OP_ADDU = 4'h3;
  localparam logic [3:0] OP_SLL  = 4'h9;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  alu_mul_seq_if #(.DATAWIDTH(16), .ALUOPWIDTH(4)) bus ();

  alu_mul_seq #(
    .MBITS(MBITS), .DATAWIDTH(16), .ALUOPWIDTH(4),
    .ALUOp_MOV(OP_MOV), .ALUOp_ADDU(OP_ADDU), .ALUOp_SLL(OP_SLL)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural alu sitting on the shared lines
  always_comb begin
    case (bus.aluOp)
      OP_ADDU: bus.aluResult = bus.aluDst + bus.aluSrc;
      OP_SLL:  bus.aluResult = bus.aluDst << bus.aluSrc[3:0];
      default: bus.aluResult = bus.aluSrc;
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Granted alu cycles an operation consumes before finishing
  function automatic int grants_needed(input logic [15:0] b);
    int msb;
`ifdef MULSEQ_EARLY_EXIT_EN
    msb = -1;
    for (int i = 0; i < MBITS; i++) if (b[i]) msb = i;
    return 2 * (msb + 1);
`else
    msb = int'(b[0]);
    return 2 * MBITS + msb - msb;
`endif
  endfunction

  function automatic int exp_lat(input logic [15:0] b, input int gmode);
    int g;
    g = grants_needed(b);
    if (g == 0) return 1;
    return (gmode == 1) ? 2 * g + 1 : g + 1;
  endfunction

  // Reference: idle / running (counting remaining grants) / done cycle
  logic [15:0] expq[$];
  int ph;
  int need;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if (ph != 0 && expq.size() > 0) void'(expq.pop_back());
      ph   = 0;
      need = 0;
    end else begin
      case (ph)
        0: if (bus.start) begin
          logic [15:0] a8, b8;
          a8 = {8'h00, bus.opA[7:0]};
          b8 = {8'h00, bus.opB[7:0]};
          expq.push_back(a8 * b8);
          need = grants_needed(bus.opB);
          ph = (need == 0) ? 2 : 1;
        end
        1: if (bus.aluGnt) begin
          need--;
          if (need == 0) ph = 2;
        end
        default: ph = 0;
      endcase
    end
  end

  logic [15:0] last_prod;

  always @(negedge clk) begin
    if (!rst_n) begin
      last_prod = 16'h0;
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_req", 32'(bus.aluReq), 32'd0);
      chk("rst_product", 32'(bus.product), 32'd0);
      chk("rst_aluop", 32'(bus.aluOp), 32'(OP_MOV));
    end else begin
      chk("done", 32'(bus.done), 32'(ph == 2));
      chk("busy", 32'(bus.busy), 32'(ph == 1));
      chk("aluReq", 32'(bus.aluReq), 32'(ph == 1));
      if (ph != 1) begin
        chk("idle_aluop", 32'(bus.aluOp), 32'(OP_MOV));
        chk("idle_alulines", {bus.aluSrc, bus.aluDst}, 32'd0);
      end
      if (bus.done) begin
        if (expq.size() == 0) begin
          chk("done_without_op", 32'd1, 32'd0);
        end else begin
          last_prod = expq.pop_front();
          chk("product", 32'(bus.product), 32'(last_prod));
        end
      end else begin
        chk("product_hold", 32'(bus.product), 32'(last_prod));
      end
    end
  end

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int gmode,
                        input int exp_cyc, input bit noise);
    int cyc;
    bit seen;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.opA = a; bus.opB = b; bus.aluGnt = 1'b1;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      bus.start = 1'b0;
      if (gmode == 0) bus.aluGnt = 1'b1;
      else if (gmode == 1) bus.aluGnt = (cyc % 2 == 0);
      else bus.aluGnt = 1'($urandom_range(0, 1));
      if (noise && cyc == 3) begin
        bus.start = 1'b1; bus.opA = 16'($urandom); bus.opB = 16'($urandom);
      end
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
    else if (exp_cyc > 0) chk("latency", 32'(cyc), 32'(exp_cyc));
    if (noise) begin
      // start during the DONE cycle must be dropped
      bus.start = 1'b1; bus.opA = 16'($urandom); bus.opB = 16'($urandom);
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0; ph = 0; need = 0; last_prod = 16'h0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.opA = 16'h0; bus.opB = 16'h0; bus.aluGnt = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    run_op(16'h00FF, 16'h00FF, 0, exp_lat(16'h00FF, 0), 1'b0);
    run_op(16'h1234, 16'hAB05, 0, exp_lat(16'hAB05, 0), 1'b0);
    run_op(16'h0003, 16'h0007, 1, exp_lat(16'h0007, 1), 1'b0);
    run_op(16'h0011, 16'h0022, 0, exp_lat(16'h0022, 0), 1'b1);
    run_op(16'h0009, 16'h0000, 0, exp_lat(16'h0000, 0), 1'b0);
    run_op(16'h0009, 16'h0002, 0, exp_lat(16'h0002, 0), 1'b0);
    run_op(16'hFF80, 16'h0080, 1, exp_lat(16'h0080, 1), 1'b0);

    // Reset in the fifth cycle of an operation aborts it
    @(posedge clk); #1;
    bus.start = 1'b1; bus.opA = 16'h00C3; bus.opB = 16'h00DA; bus.aluGnt = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 32'(bus.busy), 32'd0);
    chk("async_rst_req", 32'(bus.aluReq), 32'd0);
    chk("async_rst_product", 32'(bus.product), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_op(16'h0003, 16'h0007, 0, exp_lat(16'h0007, 0), 1'b0);

    for (int i = 0; i < 40; i++) begin
      int gm;
      gm = (i % 3 == 0) ? 0 : 2;
      begin
        logic [15:0] ra, rb;
        ra = 16'($urandom);
        rb = 16'($urandom);
        if (i % 7 == 0) rb[7:0] = 8'(1 << $urandom_range(0, 7));
        run_op(ra, rb, gm, (gm == 0) ? exp_lat(rb, 0) : 0, ($urandom_range(0, 3) == 0));
      end
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(expq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
